cla_adder_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one `carry_lookahead_adder` instance (32-bit A/B, 33-bit SUM) among `N_REQ` requesters. It sits between requester clients and the adder. It accepts one operand pair per cycle over valid/ready, registers the operands into the adder, and returns the registered 33-bit sum tagged with the requester index. Backpressure from the response side stalls the pipeline without losing data.

---
 rtl/cla_adder_arbiter.sv | 146 ++++++++++++++
 tb/tb_cla_adder_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter feeding a two-stage operand/result pipeline around one
// 32-bit carry-lookahead adder. Responses carry the winning requester's index.
module cla_adder_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [32:0]           rsp_sum,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready
);

    // Stage 1 operand register
    logic            op_valid_q;
    logic [31:0]     op_a_q;
    logic [31:0]     op_b_q;
    logic [ID_W-1:0] op_id_q;
    logic [ID_W-1:0] rr_ptr_q;

    // Pipeline control
    logic s2_adv;
    logic s1_free;

    // Arbitration results
    logic            any_valid;
    logic            found_hi;
    logic [ID_W-1:0] win_hi;
    logic [ID_W-1:0] win_lo;
    logic [ID_W-1:0] grant_id;
    logic            grant_en;
    logic [31:0]     grant_a;
    logic [31:0]     grant_b;
    logic [ID_W-1:0] rr_ptr_d;

    // Adder internals
    logic [31:0] add_g;
    logic [31:0] add_p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [32:0] add_c;
    logic [32:0] add_sum;

    assign s2_adv  = op_valid_q && (!rsp_valid || rsp_ready);
    assign s1_free = !op_valid_q || s2_adv;

    // Carry-lookahead adder: 4-bit lookahead groups, group carries chained across groups
    always_comb begin
        add_g = op_a_q & op_b_q;
        add_p = op_a_q ^ op_b_q;
        grp_g = '0;
        grp_p = '0;
        add_c = '0;
        for (int j = 0; j < 8; j++) begin
            grp_p[j] = add_p[4*j] & add_p[4*j+1] & add_p[4*j+2] & add_p[4*j+3];
            grp_g[j] = add_g[4*j+3]
                     | (add_p[4*j+3] & add_g[4*j+2])
                     | (add_p[4*j+3] & add_p[4*j+2] & add_g[4*j+1])
                     | (add_p[4*j+3] & add_p[4*j+2] & add_p[4*j+1] & add_g[4*j]);
        end
        for (int j = 0; j < 8; j++) begin
            add_c[4*j+4] = grp_g[j] | (grp_p[j] & add_c[4*j]);
        end
        for (int j = 0; j < 8; j++) begin
            for (int b = 1; b < 4; b++) begin
                add_c[4*j+b] = add_g[4*j+b-1] | (add_p[4*j+b-1] & add_c[4*j+b-1]);
            end
        end
        add_sum = {add_c[32], add_p ^ add_c[31:0]};
    end

    // Round-robin pick: first valid at or above rr_ptr, else first valid overall
    always_comb begin
        any_valid = 1'b0;
        found_hi  = 1'b0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !any_valid) begin
                any_valid = 1'b1;
                win_lo    = ID_W'(i);
            end
            if (req_valid[i] && !found_hi && (ID_W'(i) >= rr_ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = ID_W'(i);
            end
        end
        grant_id = found_hi ? win_hi : win_lo;
        grant_en = any_valid && s1_free && !rst;
        rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end

    // One-hot grant and operand mux for the winner
    always_comb begin
        req_ready = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                req_ready[i] = grant_en;
                grant_a      = req_a[32*i +: 32];
                grant_b      = req_b[32*i +: 32];
            end
        end
    end

    // Stage 1 operand register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else if (grant_en) begin
            op_valid_q <= 1'b1;
            op_a_q     <= grant_a;
            op_b_q     <= grant_b;
            op_id_q    <= grant_id;
            rr_ptr_q   <= rr_ptr_d;
        end else if (s2_adv) begin
            op_valid_q <= 1'b0;
        end
    end

    // Stage 2 result register; holds steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else if (s2_adv) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_id    <= op_id_q;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Directed and random checks of the shared-adder arbiter pipeline.
module tb_cla_adder_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [32:0]     rsp_sum;
    logic [1:0]      rsp_id;
    logic            rsp_ready;

    int checks;
    int errors;

    int          exp_id_q[$];
    logic [32:0] exp_sum_q[$];

    cla_adder_arbiter #(
        .N_REQ (N),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [32:0] req_sum(input int i);
        return {1'b0, req_a[32*i +: 32]} + {1'b0, req_b[32*i +: 32]};
    endfunction

    // Pop the oldest expected result and compare it with the current response
    task automatic pop_compare(input string name);
        checks++;
        if (exp_id_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected response id %0d sum %h", name, rsp_id, rsp_sum);
        end else begin
            int          eid;
            logic [32:0] esum;
            eid  = exp_id_q.pop_front();
            esum = exp_sum_q.pop_front();
            if (rsp_id !== 2'(eid) || rsp_sum !== esum) begin
                errors++;
                $display("FAIL %s got id %0d sum %h want id %0d sum %h",
                         name, rsp_id, rsp_sum, eid, esum);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 33'h0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got v%b sum %h id %0d want v0 sum 0 id 0",
                     rsp_valid, rsp_sum, rsp_id);
        end
        rst       = 1'b0;
        req_valid = '0;
        #1;
    endtask

    task automatic test_single();
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency got v%b want v0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 33'h0_8000_0000 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_result got v%b sum %h id %0d want v1 sum 080000000 id 0",
                     rsp_valid, rsp_sum, rsp_id);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain got v%b want v0", rsp_valid);
        end
    endtask

    task automatic test_carry();
        set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL carry_grant0 got %b want 0100", req_ready);
        end
        tick();
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0001);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL carry_grant1 got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 33'h1_FFFF_FFFE || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL carry_sum0 got v%b sum %h id %0d want v1 sum 1fffffffe id 2",
                     rsp_valid, rsp_sum, rsp_id);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 33'h1_0000_0000 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL carry_sum1 got v%b sum %h id %0d want v1 sum 100000000 id 2",
                     rsp_valid, rsp_sum, rsp_id);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h1234_5678, 32'(i));
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) begin
                logic [N-1:0] want;
                want = 4'b0001 << (c % 4);
                checks++;
                if (req_ready !== want) begin
                    errors++; $display("FAIL rr_grant c%0d got %b want %b", c, req_ready, want);
                end
            end
            if (c >= 2) begin
                int          wid;
                logic [32:0] wsum;
                wid  = (c - 2) % 4;
                wsum = 33'h0_1234_5678 + 33'(wid);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(wid) || rsp_sum !== wsum) begin
                    errors++;
                    $display("FAIL rr_rsp c%0d got v%b id %0d sum %h want v1 id %0d sum %h",
                             c, rsp_valid, rsp_id, rsp_sum, wid, wsum);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int hs_count;
        int got;
        do_reset();
        exp_id_q.delete();
        exp_sum_q.delete();
        for (int i = 0; i < N; i++) set_req(i, 32'h9000_0000 + 32'(i) * 32'h3333_3333, 32'h8000_0001);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        hs_count  = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_count++;
                    exp_id_q.push_back(i);
                    exp_sum_q.push_back(req_sum(i));
                end
            end
            if (c >= 2) begin
                checks++;
                if (req_ready !== 4'b0000) begin
                    errors++; $display("FAIL bp_stall_ready c%0d got %b want 0000", c, req_ready);
                end
                checks++;
                if (rsp_valid !== 1'b1 || rsp_sum !== req_sum(0)) begin
                    errors++;
                    $display("FAIL bp_stable c%0d got v%b sum %h want v1 sum %h",
                             c, rsp_valid, rsp_sum, req_sum(0));
                end
            end
            tick();
        end
        checks++;
        if (hs_count != 2) begin
            errors++; $display("FAIL bp_accepted got %0d want 2", hs_count);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        got       = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rsp_valid) begin
                got++;
                pop_compare("bp_drain");
            end
            tick();
        end
        checks++;
        if (got != 2 || exp_id_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got %0d left %0d want 2 left 0", got, exp_id_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        // Pointer sits at 2 here, so grants go 3 then 1
        set_req(1, 32'h0000_1111, 32'h0000_2222);
        set_req(3, 32'h0000_3333, 32'h0000_4444);
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_full_stall got v%b ready %b want v1 ready 0000", rsp_valid, req_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_ready got %b want 0000", req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 33'h0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_cleared got v%b sum %h id %0d want v0 sum 0 id 0",
                     rsp_valid, rsp_sum, rsp_id);
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_first_grant got %b want 0010", req_ready);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL mid_discard c%0d got v%b want v0", c, rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        int          mptr;
        int          waits[N];
        logic        prev_stall;
        logic [32:0] prev_sum;
        logic [1:0]  prev_id;
        do_reset();
        exp_id_q.delete();
        exp_sum_q.delete();
        mptr       = 0;
        prev_stall = 1'b0;
        prev_sum   = '0;
        prev_id    = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int g;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(1, 0) == 1)) begin
                    req_valid[i] = 1'b1;
                    set_req(i, $urandom, $urandom);
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_sum !== prev_sum || rsp_id !== prev_id) begin
                    errors++;
                    $display("FAIL rnd_hold cyc%0d got v%b sum %h id %0d want v1 sum %h id %0d",
                             cyc, rsp_valid, rsp_sum, rsp_id, prev_sum, prev_id);
                end
            end
            if (rsp_valid && rsp_ready) pop_compare("rnd_result");
            prev_stall = rsp_valid && !rsp_ready;
            prev_sum   = rsp_sum;
            prev_id    = rsp_id;
            g = -1;
            if (req_ready != '0) begin
                int want;
                want = rr_pick(req_valid, mptr);
                checks++;
                if (want < 0 || req_ready !== (4'b0001 << want)) begin
                    errors++;
                    $display("FAIL rnd_grant cyc%0d got %b want idx %0d", cyc, req_ready, want);
                end
                for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) g = i;
            end
            if (g >= 0) begin
                exp_id_q.push_back(g);
                exp_sum_q.push_back(req_sum(g));
                mptr     = (g + 1) % N;
                waits[g] = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != g && req_valid[i]) begin
                        waits[i]++;
                        checks++;
                        if (waits[i] > N - 1) begin
                            errors++;
                            $display("FAIL rnd_fair cyc%0d req %0d waited %0d want <= %0d",
                                     cyc, i, waits[i], N - 1);
                        end
                    end
                end
            end
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid) pop_compare("rnd_drain");
            tick();
        end
        checks++;
        if (exp_id_q.size() != 0) begin
            errors++; $display("FAIL rnd_lost got %0d outstanding want 0", exp_id_q.size());
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
